pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
Generic, parametrised pipeline stage register. It is the successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a data payload, a control payload and a register-ID payload under a valid/ready handshake.
- A 2-entry skid buffer gives full throughput with a registered in_ready.
- Stall means hold, not clear. Flush inserts a bubble.
- One instance per stage boundary.

Parameters:
DATA_W, 128, data payload width (e.g. pc, rs1 data, rs2 data, imm)
CTRL_W, 16, control payload width (regWrite, memRead, aluControl, ...); zeroed on bubbles
ID_W, 15, register-ID payload width (rs1/rs2/rd for forwarding and hazard logic)
CLEAR_DATA_ON_FLUSH, 0, when 1, flush also zeroes data and ID fields

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
flush  input  1  synchronous kill of all held entries (branch/jump redirect)
in_valid  input  1  upstream beat valid
in_ready  output  1  stage can accept a beat
in_data  input  DATA_W  upstream data payload
in_ctrl  input  CTRL_W  upstream control payload
in_id  input  ID_W  upstream register IDs
out_valid  output  1  downstream beat valid
out_ready  input  1  downstream accepts beat (deasserted = stall)
out_data  output  DATA_W  data payload of head entry
out_ctrl  output  CTRL_W  control payload of head entry, forced 0 when out_valid=0
out_id  output  ID_W  register IDs of head entry, forced 0 when out_valid=0
occupancy  output  2  number of held entries (0..2)

Behaviour:
- Reset (reset=0, asynchronous): both entries invalid; all payload registers 0; out_valid=0; out_ctrl=0; out_id=0; out_data=0; occupancy=0; in_ready=1 after release.
- Storage has two entries:
  - main: drives the outputs.
  - skid: catches a beat accepted while main is stalled.
- Handshake signals:
  - in_ready = !skid_valid && !flush. Only the flush term is combinational; skid_valid is registered.
  - accept = in_valid && in_ready.
  - drain = out_valid && out_ready.
- States follow occupancy: EMPTY (0), ONE (main valid), FULL (main and skid valid).
- EMPTY:
  - accept: main <= in, go to ONE.
  - otherwise: stay.
- ONE:
  - accept and drain: main <= in, stay ONE.
  - accept only: skid <= in, go to FULL.
  - drain only: go to EMPTY.
  - neither: hold.
- FULL (in_ready=0):
  - drain: main <= skid, skid invalid, go to ONE.
  - otherwise: hold.
- Latency: a beat accepted at edge N appears on out_* after edge N.
- Throughput: 1 beat/cycle while out_ready=1. Order is strictly preserved; no beat is duplicated or lost.
- Stall (out_ready=0, out_valid=1): out_data/out_ctrl/out_id must remain bit-stable until drain. At most one further beat is absorbed (into skid).
- Flush (highest priority below reset), at the clock edge:
  - Both entries become invalid, occupancy becomes 0, and ctrl/id registers are zeroed.
  - Data is retained unless CLEAR_DATA_ON_FLUSH=1.
  - Any in_valid in the flush cycle is not accepted (in_ready=0).
  - A simultaneous drain is still reported to downstream. Downstream owns the flush policy for that beat.
- Bubble rule: out_ctrl and out_id are AND-gated with out_valid. An empty stage therefore never asserts regWrite/memWrite downstream.
- Reset mid-operation: immediate clear regardless of state or handshake.
- No X on outputs after reset. The in_valid/in_data contract is not checked (upstream responsibility).

Decomposition:
- Shared package pipe_pkg:
  - occupancy/state encodings: ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2.
  - Per-boundary field-width constants, e.g. ID/EX: DATA_W=128, CTRL_W=16, ID_W=15.
  - Control bit offsets: REGWRITE_BIT, MEMREAD_BIT, MEMWRITE_BIT, MEMTOREG_BIT, ALUSRC_BIT, BRANCH_BIT, JUMP_BIT, BEQ_BIT, BNE_BIT, ALUCTRL_LSB (4 bits).
- One sub-module: pipe_entry_reg, a single valid+payload register with load/clear/flush.
  - Instantiated twice (main, skid).
  - The top contains the occupancy FSM and muxing.

Test Plan:
1. Reset: hold reset=0 while driving in_valid=1, in_ctrl=16'hFFFF -> out_valid=0, out_ctrl=0, occupancy=0. After release, in_ready=1.
2. Streaming: out_ready=1; send beats data=1,2,3,4 on consecutive cycles -> out_data=1,2,3,4 one cycle later each; occupancy stays 1; no stall cycles.
3. Stall/skid: beat A accepted; out_ready=0; beat B offered -> B accepted, occupancy=2, in_ready=0, out_data=A stable. Release out_ready -> A then B emitted; C is not accepted until occupancy<2.
4. Flush when FULL: occupancy=2 with ctrl=16'h00FF; assert flush together with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_ctrl=0, out_id=0; the input beat is not accepted. Check data retained (CLEAR_DATA_ON_FLUSH=0) or zeroed (=1).
5. Bubble gating: empty stage with in_ctrl toggling and in_valid=0 -> out_ctrl stays 0 and out_valid stays 0.
6. Async reset mid-stall: occupancy=2; pulse reset low between clock edges -> outputs clear immediately without a clock edge; stage resumes normally afterwards.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared encodings and field layouts for pipeline stage registers
// Contents: occupancy/state enum, per-boundary payload widths, control bit offsets.
package pipe_pkg;
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_FULL = 2'd2} state_t;
  localparam int IFID_DATA_W  = 64;
  localparam int IFID_CTRL_W  = 1;
  localparam int IFID_ID_W    = 15;
  localparam int IDEX_DATA_W  = 128;
  localparam int IDEX_CTRL_W  = 16;
  localparam int IDEX_ID_W    = 15;
  localparam int EXMEM_DATA_W = 96;
  localparam int EXMEM_CTRL_W = 16;
  localparam int EXMEM_ID_W   = 5;
  localparam int MEMWB_DATA_W = 64;
  localparam int MEMWB_CTRL_W = 16;
  localparam int MEMWB_ID_W   = 5;
  localparam int REGWRITE_BIT = 0;
  localparam int MEMREAD_BIT  = 1;
  localparam int MEMWRITE_BIT = 2;
  localparam int MEMTOREG_BIT = 3;
  localparam int ALUSRC_BIT   = 4;
  localparam int BRANCH_BIT   = 5;
  localparam int JUMP_BIT     = 6;
  localparam int BEQ_BIT      = 7;
  localparam int BNE_BIT      = 8;
  localparam int ALUCTRL_LSB  = 9;
  localparam int ALUCTRL_W    = 4;
endpackage

// File: rtl/pipe_entry_reg.sv
// pipe_entry_reg: one valid+payload register slot with load, clear and flush
// Ports: clk/reset (async active-low); load captures next_* and sets valid;
// clear drops valid keeping payload; flush drops valid and zeroes ctrl/id
// (and data when CLEAR_DATA_ON_FLUSH); valid/data/ctrl/id are the held entry.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = IDEX_DATA_W,
  parameter int CTRL_W = IDEX_CTRL_W,
  parameter int ID_W = IDEX_ID_W,
  parameter bit CLEAR_DATA_ON_FLUSH = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic              flush,
  input  logic [DATA_W-1:0] next_data,
  input  logic [CTRL_W-1:0] next_ctrl,
  input  logic [ID_W-1:0]   next_id,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl,
  output logic [ID_W-1:0]   id
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= '0;
      id    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      ctrl  <= '0;
      id    <= '0;
      if (CLEAR_DATA_ON_FLUSH) data <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= next_data;
      ctrl  <= next_ctrl;
      id    <= next_id;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline stage register with 2-entry skid buffer
// Ports: clk, reset (async active-low), flush (sync kill); in_valid/in_ready
// with in_data/in_ctrl/in_id upstream; out_valid/out_ready with
// out_data/out_ctrl/out_id downstream (ctrl/id gated by out_valid);
// occupancy = held entries (0..2).
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = IDEX_DATA_W,
  parameter int CTRL_W = IDEX_CTRL_W,
  parameter int ID_W = IDEX_ID_W,
  parameter bit CLEAR_DATA_ON_FLUSH = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [ID_W-1:0]   in_id,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [ID_W-1:0]   out_id,
  output logic [1:0]        occupancy
);
  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [ID_W-1:0]   main_id, skid_id;
  logic              accept, drain;
  logic              main_load, main_clear, skid_load, skid_clear;
  state_t            state;
  always_comb begin
    state      = skid_valid ? ST_FULL : main_valid ? ST_ONE : ST_EMPTY;
    in_ready   = !skid_valid && !flush;
    accept     = in_valid && in_ready;
    drain      = main_valid && out_ready;
    // FULL refills main from skid on drain; otherwise main takes the input
    // whenever it is empty or being emptied this cycle.
    main_load  = skid_valid ? drain : accept && (!main_valid || drain);
    main_clear = main_valid && !skid_valid && drain && !accept;
    skid_load  = main_valid && !drain && accept;
    skid_clear = skid_valid && drain;
  end
  pipe_entry_reg #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .ID_W(ID_W),
    .CLEAR_DATA_ON_FLUSH(CLEAR_DATA_ON_FLUSH)
  ) u_main (
    .clk(clk), .reset(reset), .load(main_load), .clear(main_clear), .flush(flush),
    .next_data(skid_valid ? skid_data : in_data),
    .next_ctrl(skid_valid ? skid_ctrl : in_ctrl),
    .next_id(skid_valid ? skid_id : in_id),
    .valid(main_valid), .data(main_data), .ctrl(main_ctrl), .id(main_id)
  );
  pipe_entry_reg #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .ID_W(ID_W),
    .CLEAR_DATA_ON_FLUSH(CLEAR_DATA_ON_FLUSH)
  ) u_skid (
    .clk(clk), .reset(reset), .load(skid_load), .clear(skid_clear), .flush(flush),
    .next_data(in_data), .next_ctrl(in_ctrl), .next_id(in_id),
    .valid(skid_valid), .data(skid_data), .ctrl(skid_ctrl), .id(skid_id)
  );
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign out_id    = main_valid ? main_id : '0;
  assign occupancy = state;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed and random checks of pipe_stage_skid against a queue model
module tb_pipe_stage_skid;
  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  ctrl;
    logic [14:0]  id;
  } beat_t;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [15:0]  in_ctrl = '0;
  logic [14:0]  in_id = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic [15:0]  out_ctrl;
  logic [14:0]  out_id;
  logic [1:0]   occupancy;
  int           total = 0;
  int           bad = 0;
  beat_t        q[$];
  logic [127:0] hd = '0;
  pipe_stage_skid #(
    .DATA_W(128), .CTRL_W(16), .ID_W(15), .CLEAR_DATA_ON_FLUSH(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_id(in_id),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_id(out_id),
    .occupancy(occupancy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_outputs();
    beat_t h;
    h = q.size() != 0 ? q[0] : '0;
    chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
    chk("occupancy", 128'(occupancy), 128'(q.size()));
    chk("out_ctrl", 128'(out_ctrl), 128'(h.ctrl));
    chk("out_id", 128'(out_id), 128'(h.id));
    chk("out_data", out_data, hd);
  endtask
  // One clock: check current state, drive inputs, advance the model past the next edge.
  task automatic cyc(input logic v, input logic [127:0] d, input logic [15:0] c,
                     input logic [14:0] i, input logic r, input logic f);
    logic acc, dr;
    @(negedge clk);
    check_outputs();
    in_valid = v; in_data = d; in_ctrl = c; in_id = i; out_ready = r; flush = f;
    #1;
    chk("in_ready", 128'(in_ready), 128'(q.size() < 2 && !f));
    acc = v && q.size() < 2 && !f;
    dr = q.size() != 0 && r;
    if (f) q.delete();
    else begin
      if (dr) void'(q.pop_front());
      if (acc) q.push_back('{data: d, ctrl: c, id: i});
    end
    if (q.size() != 0) hd = q[0].data;
  endtask
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  initial begin
    in_valid = 1'b1; in_ctrl = 16'hFFFF; in_data = '1; in_id = '1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_out_ctrl", 128'(out_ctrl), 128'(0));
      chk("rst_out_id", 128'(out_id), 128'(0));
      chk("rst_out_data", out_data, 128'(0));
      chk("rst_occupancy", 128'(occupancy), 128'(0));
    end
    in_valid = 1'b0;
    reset = 1'b1;
    for (int k = 1; k <= 4; k++) cyc(1'b1, 128'(k), 16'(k), 15'(k), 1'b1, 1'b0);
    repeat (2) cyc(1'b0, '0, '0, '0, 1'b1, 1'b0);
    cyc(1'b1, 128'hA, 16'h0A, 15'h0A, 1'b1, 1'b0);
    cyc(1'b1, 128'hB, 16'h0B, 15'h0B, 1'b0, 1'b0);
    cyc(1'b1, 128'hC, 16'h0C, 15'h0C, 1'b0, 1'b0);
    cyc(1'b1, 128'hC, 16'h0C, 15'h0C, 1'b0, 1'b0);
    cyc(1'b1, 128'hC, 16'h0C, 15'h0C, 1'b1, 1'b0);
    cyc(1'b1, 128'hD, 16'h0D, 15'h0D, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, '0, '0, '0, 1'b1, 1'b0);
    cyc(1'b1, 128'h11, 16'h00FF, 15'h11, 1'b0, 1'b0);
    cyc(1'b1, 128'h22, 16'h00FF, 15'h22, 1'b0, 1'b0);
    cyc(1'b1, 128'h33, 16'h00FF, 15'h33, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) cyc(1'b0, '0, (k % 2) ? 16'hFFFF : 16'h5A5A, 15'h7FFF, 1'b1, 1'b0);
    cyc(1'b1, 128'h44, 16'h1234, 15'h44, 1'b0, 1'b0);
    cyc(1'b1, 128'h55, 16'h5678, 15'h55, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    check_outputs();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_out_valid", 128'(out_valid), 128'(0));
    chk("arst_occupancy", 128'(occupancy), 128'(0));
    chk("arst_out_ctrl", 128'(out_ctrl), 128'(0));
    chk("arst_out_data", out_data, 128'(0));
    q.delete();
    hd = '0;
    reset = 1'b1;
    for (int k = 0; k < 3000; k++)
      cyc($urandom_range(0, 9) < 7, rnd128(), 16'($urandom), 15'($urandom),
          $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
    repeat (3) cyc(1'b0, '0, '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    check_outputs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
